// File: rtl/main_memory_pkg.sv
// Shared types and default geometry for the block-read / word-write backing memory.
package main_memory_pkg;

  localparam int ADDR_W_DEF      = 10;
  localparam int DATA_W_DEF      = 32;
  localparam int BLOCK_WORDS_DEF = 4;
  localparam int LATENCY_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter needs at least one bit even when LATENCY is 1.
  function automatic int cntWidth(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/main_memory_mem_array.sv
// Word-addressed storage: one synchronous word-write port, one combinational block-read port.
// Contents are never reset.
module mem_array #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          wrEn,
  input  logic [ADDR_W-1:0]             wrAddr,
  input  logic [DATA_W-1:0]             wrData,
  input  logic [ADDR_W-1:0]             rdAddr,
  output logic [BLOCK_WORDS*DATA_W-1:0] rdBlock
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] blockBase;

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Clearing the offset bits keeps every block inside the array, so no access can go out of range.
  assign blockBase = rdAddr & ~ADDR_W'(BLOCK_WORDS - 1);

  for (genvar i = 0; i < BLOCK_WORDS; i++) begin : gBlk
    assign rdBlock[DATA_W*i +: DATA_W] = mem[blockBase | ADDR_W'(i)];
  end

endmodule

// File: rtl/main_memory.sv
// Fixed-latency main memory: block reads, word writes, ready pulse LATENCY cycles after accept.
// Optional conflict pulse mem_err is present only when MAIN_MEM_ERR_EN is defined.
module main_memory
  import main_memory_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int LATENCY     = LATENCY_DEF
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_ready,
  output logic [BLOCK_WORDS*DATA_W-1:0] mem_rdata
`ifdef MAIN_MEM_ERR_EN
  ,
  output logic                          mem_err
`endif
);

  localparam int CNT_W = cntWidth(LATENCY);

  state_t                          state, nextState;
  logic [CNT_W-1:0]                cnt;
  logic                            opWrite;
  logic [ADDR_W-1:0]               addrQ;
  logic [DATA_W-1:0]               wdataQ;
  logic                            accept;
  logic                            execute;
  logic                            arrWe;
  logic [BLOCK_WORDS*DATA_W-1:0]   blockData;

  // The edge leaving DONE may accept a held request, giving a LATENCY+1 turnaround.
  assign accept  = ((state == IDLE) || (state == DONE)) && (mem_read || mem_write);
  assign execute = (state == BUSY) && (cnt == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = BUSY;
      BUSY:    if (execute) nextState = DONE;
      DONE:    nextState = accept ? BUSY : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (state == DONE);
    arrWe     = execute && opWrite;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt       <= '0;
      opWrite   <= 1'b0;
      addrQ     <= '0;
      wdataQ    <= '0;
      mem_rdata <= '0;
    end else begin
      if (accept) begin
        opWrite <= mem_write;
        addrQ   <= mem_addr;
        wdataQ  <= mem_wdata;
        cnt     <= CNT_W'(LATENCY - 1);
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (execute && !opWrite) begin
        mem_rdata <= blockData;
      end
    end
  end

`ifdef MAIN_MEM_ERR_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem_err <= 1'b0;
    end else begin
      mem_err <= accept && mem_read && mem_write;
    end
  end
`endif

  mem_array #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) uArray (
    .clk     (CLK),
    .wrEn    (arrWe),
    .wrAddr  (addrQ),
    .wrData  (wdataQ),
    .rdAddr  (addrQ),
    .rdBlock (blockData)
  );

endmodule

// File: tb/tb_main_memory.sv
// Scoreboarded bench for main_memory: latency, block reads, hold/re-accept, conflicts, reset abort.
module tb_main_memory;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int LAT = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              mem_read = 1'b0;
  logic              mem_write = 1'b0;
  logic [AW-1:0]     mem_addr = '0;
  logic [DW-1:0]     mem_wdata = '0;
  logic              mem_ready;
  logic [BW*DW-1:0]  mem_rdata;
`ifdef MAIN_MEM_ERR_EN
  logic              mem_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0]     model [0:(1<<AW)-1];
  bit                known [0:(1<<AW)-1];
  logic [BW*DW-1:0]  curExp;
  logic [BW*DW-1:0]  curMask;
  logic [BW*DW-1:0]  expQ[$];
  logic [BW*DW-1:0]  mskQ[$];

  always #5 CLK = ~CLK;

  main_memory dut (
    .CLK       (CLK),
    .RST       (RST),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
`ifdef MAIN_MEM_ERR_EN
    ,
    .mem_err   (mem_err)
`endif
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic modelBlock(input logic [AW-1:0] a, output logic [BW*DW-1:0] e,
                            output logic [BW*DW-1:0] m);
    logic [AW-1:0] base;
    base = a & ~AW'(BW - 1);
    e = '0;
    m = '0;
    for (int i = 0; i < BW; i++) begin
      if (known[base + AW'(i)]) begin
        e[DW*i +: DW] = model[base + AW'(i)];
        m[DW*i +: DW] = '1;
      end
    end
  endtask

  // One complete request: model update, drive, latency/hold/data/width checks.
  task automatic access(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    logic [BW*DW-1:0] prevE, prevM, e, m;
    int lat;
    prevE = curExp;
    prevM = curMask;
    if (wr) begin
      model[a] = d;
      known[a] = 1'b1;
    end else begin
      modelBlock(a, e, m);
      curExp  = e;
      curMask = m;
    end
    expQ.push_back(curExp);
    mskQ.push_back(curMask);
    @(negedge CLK);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
    @(posedge CLK); #1;
`ifdef MAIN_MEM_ERR_EN
    vectors++;
    if (mem_err !== (rd && wr)) begin
      miscompares++;
      $display("FAIL err_pulse addr=%h got=%b want=%b", a, mem_err, rd && wr);
    end
`endif
    lat = 0;
    while (!mem_ready && lat < 20) begin
      vectors++;
      if ((mem_rdata & prevM) !== (prevE & prevM)) begin
        miscompares++;
        $display("FAIL rdata_hold addr=%h got=%h want=%h", a, mem_rdata, prevE);
      end
      @(posedge CLK); #1;
      lat++;
`ifdef MAIN_MEM_ERR_EN
      vectors++;
      if (mem_err !== 1'b0) begin
        miscompares++;
        $display("FAIL err_width addr=%h got=%b want=0", a, mem_err);
      end
`endif
    end
    vectors++;
    if (lat !== LAT) begin
      miscompares++;
      $display("FAIL ready_latency addr=%h got=%0d want=%0d", a, lat, LAT);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    e = expQ.pop_front();
    m = mskQ.pop_front();
    vectors++;
    if ((mem_rdata & m) !== (e & m)) begin
      miscompares++;
      $display("FAIL rdata addr=%h got=%h want=%h", a, mem_rdata, e);
    end
    @(posedge CLK); #1;
    vectors++;
    if (mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_width addr=%h got=%b want=0", a, mem_ready);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    vectors++;
    if (mem_ready !== 1'b0 || mem_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_state ready=%b rdata=%h want 0/0", mem_ready, mem_rdata);
    end
`ifdef MAIN_MEM_ERR_EN
    vectors++;
    if (mem_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err got=%b want=0", mem_err);
    end
`endif
    @(negedge CLK);
    RST = 1'b1;
    curExp  = '0;
    curMask = '1;
  endtask

  task automatic test_top_word();
    access(1'b0, 1'b1, 10'h3ff, 32'h3ff);
    access(1'b1, 1'b0, 10'h3fc, 32'h0);
    vectors++;
    if (mem_rdata[127:96] !== 32'h0000_03ff) begin
      miscompares++;
      $display("FAIL top_word got=%h want=000003ff", mem_rdata[127:96]);
    end
  endtask

  task automatic test_block_read();
    logic [BW*DW-1:0] want;
    for (int i = 'h3f4; i <= 'h3ff; i++) begin
      access(1'b0, 1'b1, AW'(i), DW'(i));
    end
    access(1'b1, 1'b0, 10'h3f8, 32'h0);
    want = 128'h000003fb_000003fa_000003f9_000003f8;
    vectors++;
    if (mem_rdata !== want) begin
      miscompares++;
      $display("FAIL block_3f8 got=%h want=%h", mem_rdata, want);
    end
    access(1'b1, 1'b0, 10'h3fe, 32'h0);
    want = 128'h000003ff_000003fe_000003fd_000003fc;
    vectors++;
    if (mem_rdata !== want) begin
      miscompares++;
      $display("FAIL block_wrap got=%h want=%h", mem_rdata, want);
    end
  endtask

  task automatic test_hold_read();
    logic [BW*DW-1:0] e, m;
    int pulses, first, second;
    modelBlock(10'h3f4, e, m);
    expQ.push_back(e);
    mskQ.push_back(m);
    expQ.push_back(e);
    mskQ.push_back(m);
    @(negedge CLK);
    mem_read = 1'b1;
    mem_addr = 10'h3f4;
    @(posedge CLK); #1;
    pulses = 0;
    first  = -1;
    second = -1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge CLK); #1;
      if (mem_ready) begin
        pulses++;
        if (first < 0) first = c;
        else second = c;
        if (pulses >= 2) mem_read = 1'b0;
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          m = mskQ.pop_front();
          vectors++;
          if ((mem_rdata & m) !== (e & m)) begin
            miscompares++;
            $display("FAIL hold_rdata cycle=%0d got=%h want=%h", c, mem_rdata, e);
          end
        end
      end
    end
    mem_read = 1'b0;
    curExp  = e;
    curMask = m;
    vectors++;
    if (pulses !== 2 || first !== LAT || second !== 2*LAT + 1) begin
      miscompares++;
      $display("FAIL hold_reaccept pulses=%0d at %0d,%0d want 2 at %0d,%0d",
               pulses, first, second, LAT, 2*LAT + 1);
    end
  endtask

  task automatic test_conflict();
    access(1'b1, 1'b1, 10'h010, 32'hA5);
    access(1'b1, 1'b0, 10'h010, 32'h0);
    vectors++;
    if (mem_rdata[31:0] !== 32'h0000_00A5) begin
      miscompares++;
      $display("FAIL conflict_write got=%h want=000000a5", mem_rdata[31:0]);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    access(1'b0, 1'b1, 10'h020, 32'h11);
    @(negedge CLK);
    mem_write = 1'b1;
    mem_addr  = 10'h020;
    mem_wdata = 32'h55;
    @(posedge CLK);
    @(posedge CLK);
    @(posedge CLK); #1;
    RST = 1'b0;
    mem_write = 1'b0;
    #1;
    vectors++;
    if (mem_ready !== 1'b0 || mem_rdata !== '0) begin
      miscompares++;
      $display("FAIL abort_reset ready=%b rdata=%h want 0/0", mem_ready, mem_rdata);
    end
    @(negedge CLK);
    RST = 1'b1;
    curExp  = '0;
    curMask = '1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge CLK); #1;
      if (mem_ready) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL abort_ready pulses=%0d want=0", pulses);
    end
    access(1'b1, 1'b0, 10'h020, 32'h0);
    vectors++;
    if (mem_rdata[31:0] === 32'h55) begin
      miscompares++;
      $display("FAIL abort_commit got=%h want!=00000055", mem_rdata[31:0]);
    end
  endtask

  task automatic test_read_after_reset();
    for (int i = 0; i < BW; i++) begin
      access(1'b0, 1'b1, AW'(i), 32'hC0DE_0000 + DW'(i));
    end
    access(1'b1, 1'b0, 10'h3f8, 32'h0);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    vectors++;
    if (mem_rdata !== '0) begin
      miscompares++;
      $display("FAIL async_clear got=%h want=0", mem_rdata);
    end
    @(negedge CLK);
    RST = 1'b1;
    curExp  = '0;
    curMask = '1;
    access(1'b1, 1'b0, 10'h000, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    for (int i = 0; i < 8; i++) begin
      a = AW'($urandom_range('h100, 'h13f));
      access(1'b0, 1'b1, a, $urandom);
    end
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b0, AW'('h100 + 16*i + 3), 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_top_word();
    test_block_read();
    test_hold_read();
    test_conflict();
    test_reset_abort();
    test_read_after_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
